ifid_stage: RTL and testbench

IFID_STAGE -- requirements
Module: ifid_stage

---
 rtl/ifid_stage.sv | 69 ++++++
 tb/tb_ifid_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ifid_stage.sv
// Fetch-to-decode pipeline register: one entry, fully registered outputs,
// with bubble insertion, stall hold and deferred flush across a decode stall.
module ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IF_Stall,
  input  logic        IF_Flush,
  input  logic [31:0] IF_Instruction,
  input  logic [31:0] PCAdd4,
  input  logic [31:0] PCOut,
  input  logic        ID_Stall,
  input  logic        ID_IsBranch,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCAdd4,
  output logic [31:0] ID_RestartPC,
  output logic        ID_Valid,
  output logic        ID_IsBDS,
  output logic        ID_IsFlushed
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic flush_pending;
  logic flush;
  logic capture_bds;

  // A flush requested while decode was stalled is remembered and applied
  // on the first cycle decode can accept a new entry.
  assign flush       = IF_Flush | flush_pending;
  assign capture_bds = ID_IsBranch & ID_Valid;

  // NOTE: all state is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge value (capture_bds uses the old ID_Valid).
  always_ff @(posedge clock) begin
    if (reset) begin
      ID_Instruction <= NOP;
      ID_PCAdd4      <= RESET_PC + 32'd4;
      ID_RestartPC   <= RESET_PC;
      ID_Valid       <= 1'b0;
      ID_IsBDS       <= 1'b0;
      ID_IsFlushed   <= 1'b0;
      flush_pending  <= 1'b0;
    end else if (ID_Stall) begin
      flush_pending  <= flush_pending | IF_Flush;
    end else if (flush) begin
      ID_Instruction <= NOP;
      ID_Valid       <= 1'b0;
      ID_IsBDS       <= 1'b0;
      ID_IsFlushed   <= 1'b1;
      flush_pending  <= 1'b0;
    end else if (IF_Stall) begin
      ID_Instruction <= NOP;
      ID_Valid       <= 1'b0;
      ID_IsBDS       <= 1'b0;
      ID_IsFlushed   <= 1'b0;
    end else begin
      ID_Instruction <= IF_Instruction;
      ID_PCAdd4      <= PCAdd4;
      ID_Valid       <= 1'b1;
      ID_IsBDS       <= capture_bds;
      ID_IsFlushed   <= 1'b0;
      // A delay slot restarts at its branch, whose PC is already held here.
      ID_RestartPC   <= capture_bds ? ID_RestartPC : PCOut;
    end
  end

endmodule

// File: tb/tb_ifid_stage.sv
// Scoreboard bench for ifid_stage: directed vectors push hand-computed
// expected register contents; a monitor pops and compares each cycle.
module tb_ifid_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcadd4;
    logic [31:0] restart;
    logic        valid;
    logic        bds;
    logic        flushed;
  } id_state_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IF_Stall = 1'b0;
  logic        IF_Flush = 1'b0;
  logic [31:0] IF_Instruction = '0;
  logic [31:0] PCAdd4 = '0;
  logic [31:0] PCOut = '0;
  logic        ID_Stall = 1'b0;
  logic        ID_IsBranch = 1'b0;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCAdd4;
  logic [31:0] ID_RestartPC;
  logic        ID_Valid;
  logic        ID_IsBDS;
  logic        ID_IsFlushed;

  id_state_t expq[$];
  int        n_cmp = 0;
  int        n_bad = 0;
  int        step_no = 0;
  int        tags[$];

  ifid_stage dut (
    .clock          (clock),
    .reset          (reset),
    .IF_Stall       (IF_Stall),
    .IF_Flush       (IF_Flush),
    .IF_Instruction (IF_Instruction),
    .PCAdd4         (PCAdd4),
    .PCOut          (PCOut),
    .ID_Stall       (ID_Stall),
    .ID_IsBranch    (ID_IsBranch),
    .ID_Instruction (ID_Instruction),
    .ID_PCAdd4      (ID_PCAdd4),
    .ID_RestartPC   (ID_RestartPC),
    .ID_Valid       (ID_Valid),
    .ID_IsBDS       (ID_IsBDS),
    .ID_IsFlushed   (ID_IsFlushed)
  );

  always #5 clock = ~clock;

  task automatic check(input int tag, input id_state_t act, input id_state_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step%0d: got instr=%h pa4=%h rpc=%h v=%b bds=%b fl=%b, want instr=%h pa4=%h rpc=%h v=%b bds=%b fl=%b",
               tag, act.instr, act.pcadd4, act.restart, act.valid, act.bds, act.flushed,
               exp.instr, exp.pcadd4, exp.restart, exp.valid, exp.bds, exp.flushed);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the capture edge.
  always @(negedge clock) begin
    if (expq.size() > 0) begin
      id_state_t act;
      act = '{ID_Instruction, ID_PCAdd4, ID_RestartPC, ID_Valid, ID_IsBDS, ID_IsFlushed};
      check(tags.pop_front(), act, expq.pop_front());
    end
  end

  // One clock cycle: apply inputs, let the edge happen, then queue what the
  // register must hold after that edge.
  task automatic cyc(input logic rst, input logic id_stall, input logic if_stall,
                     input logic if_flush, input logic is_branch,
                     input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins,
                     input logic [31:0] e_ins, input logic [31:0] e_pa4, input logic [31:0] e_rpc,
                     input logic e_v, input logic e_bds, input logic e_fl);
    id_state_t e;
    reset          = rst;
    ID_Stall       = id_stall;
    IF_Stall       = if_stall;
    IF_Flush       = if_flush;
    ID_IsBranch    = is_branch;
    PCOut          = pc;
    PCAdd4         = pc4;
    IF_Instruction = ins;
    @(posedge clock);
    #1;
    step_no++;
    e = '{e_ins, e_pa4, e_rpc, e_v, e_bds, e_fl};
    expq.push_back(e);
    tags.push_back(step_no);
  endtask

  initial begin
    @(posedge clock);
    #1;
    //   rst sid sif fl br  PCOut      PCAdd4     Instr        | exp instr   pa4          rpc          v  bds fl
    // reset wins over stall and flush
    cyc(1, 1, 0, 1, 0, 32'h0,     32'h0,     32'hDEAD_BEEF, 32'h0,        32'hBFC0_0004, 32'hBFC0_0000, 0, 0, 0);
    // plain capture
    cyc(0, 0, 0, 0, 0, 32'h100,   32'h104,   32'h2408_0005, 32'h2408_0005, 32'h104, 32'h100, 1, 0, 0);
    // branch at 0x200 enters ID
    cyc(0, 0, 0, 0, 0, 32'h200,   32'h204,   32'h1000_0003, 32'h1000_0003, 32'h204, 32'h200, 1, 0, 0);
    // its delay slot: BDS set, restart at the branch
    cyc(0, 0, 0, 0, 1, 32'h204,   32'h208,   32'h2409_0001, 32'h2409_0001, 32'h208, 32'h200, 1, 1, 0);
    // decode stall for three cycles with busy fetch inputs
    cyc(0, 1, 0, 0, 0, 32'h300,   32'h304,   32'hAAAA_0001, 32'h2409_0001, 32'h208, 32'h200, 1, 1, 0);
    cyc(0, 1, 1, 0, 1, 32'h400,   32'h404,   32'hAAAA_0002, 32'h2409_0001, 32'h208, 32'h200, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h500,   32'h504,   32'hAAAA_0003, 32'h2409_0001, 32'h208, 32'h200, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 32'h208,   32'h20C,   32'h3C01_1234, 32'h3C01_1234, 32'h20C, 32'h208, 1, 0, 0);
    // flush during a decode stall is deferred
    cyc(0, 1, 0, 1, 0, 32'h600,   32'h604,   32'hBBBB_0001, 32'h3C01_1234, 32'h20C, 32'h208, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h600,   32'h604,   32'hBBBB_0002, 32'h3C01_1234, 32'h20C, 32'h208, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 32'h600,   32'h604,   32'hBBBB_0003, 32'h0,        32'h20C, 32'h208, 0, 0, 1);
    // exactly one flushed bubble, then capture; branch flag ignored after a bubble
    cyc(0, 0, 0, 0, 1, 32'h600,   32'h604,   32'h8C01_0004, 32'h8C01_0004, 32'h604, 32'h600, 1, 0, 0);
    // flush beats fetch stall
    cyc(0, 0, 1, 1, 0, 32'h700,   32'h704,   32'hCCCC_0001, 32'h0,        32'h604, 32'h600, 0, 0, 1);
    // fetch stall alone
    cyc(0, 0, 1, 0, 0, 32'h700,   32'h704,   32'hCCCC_0002, 32'h0,        32'h604, 32'h600, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 32'h700,   32'h704,   32'h03E0_0008, 32'h03E0_0008, 32'h704, 32'h700, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h704,   32'h708,   32'h2402_000A, 32'h2402_000A, 32'h708, 32'h700, 1, 1, 0);
    // bubble keeps PCs; the following capture must not become a delay slot
    cyc(0, 0, 1, 0, 1, 32'h708,   32'h70C,   32'hCCCC_0003, 32'h0,        32'h708, 32'h700, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h800,   32'h804,   32'h1111_1111, 32'h1111_1111, 32'h804, 32'h800, 1, 0, 0);
    // reset mid-stall with a pending flush clears the pending flush
    cyc(0, 1, 0, 1, 0, 32'h850,   32'h854,   32'hEEEE_0001, 32'h1111_1111, 32'h804, 32'h800, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 32'h860,   32'h864,   32'hEEEE_0002, 32'h0,        32'hBFC0_0004, 32'hBFC0_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 32'h900,   32'h904,   32'h2222_2222, 32'h2222_2222, 32'h904, 32'h900, 1, 0, 0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clock);
    if (expq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
